// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; never below one bit so WIDTH=2 still gets a counter.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, built from two half subtractors.
// Latency: combinational.
// Backpressure: none.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (
        .a    (a),
        .b    (b),
        .d    (d1),
        .bout (b1)
    );

    half_subtractor u_hs1 (
        .a    (d1),
        .b    (bin),
        .d    (d),
        .bout (b2)
    );

    // Second stage borrows only when a==b and a borrow came in, so the OR never double counts.
    assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// One-bit half subtractor: d = a - b, bout set when b exceeds a.
// Latency: combinational.
// Backpressure: none.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);

    assign d    = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A-B controller: one shared full_subtractor cell, LSB first, one bit per clock.
// Latency: accept edge -> done after WIDTH further edges; start-to-start spacing WIDTH+2.
// Backpressure: start sampled only in IDLE (busy low); ignored otherwise. SERIAL_SUB_OVF_EN adds overflow port.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q;
    logic             cell_d;
    logic             cell_bout;
    logic             accept;
    logic             last_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q;
    logic             b_msb_q;
`endif

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign accept   = (state_q == IDLE) && start;
    assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);
    // Result bits enter from the MSB side; after WIDTH shifts the LSB lands at bit 0.
    assign res_nxt  = {cell_d, res_sh};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand shifting, borrow chain, bit counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            cnt_q      <= '0;
            borrow_q   <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else if (accept) begin
            a_sh     <= a;
            b_sh     <= b;
            res_sh   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            // Operand MSBs are shifted away during RUN, so keep them for the overflow test.
            a_msb_q  <= a[WIDTH-1];
            b_msb_q  <= b[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            a_sh     <= a_sh >> 1;
            b_sh     <= b_sh >> 1;
            res_sh   <= res_nxt[WIDTH-1:1];
            borrow_q <= cell_bout;
            if (!last_bit) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Outputs change only here so partial results never show on diff.
            if (last_bit) begin
                diff       <= res_nxt;
                borrow_out <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                overflow   <= (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl with an expected-result queue and done-driven monitor.
// Latency: checks accept-to-done spacing and start-to-start spacing.
// Backpressure: exercises start during RUN and start held high continuously.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bor;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         overflow;
`endif

    exp_t         sb[$];
    int           n_vec;
    int           n_err;
    int           cyc_cnt;
    logic [W-1:0] held_diff;
    logic         held_bor;
    logic         done_prev;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare results on every done pulse, check hold between pulses.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_diff = '0;
            held_bor  = 1'b0;
            done_prev = 1'b0;
        end else if (done) begin
            chk("done_width", {31'd0, done_prev}, 32'd0);
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("diff", {24'd0, diff}, {24'd0, e.diff});
                chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.bor});
`ifdef SERIAL_SUB_OVF_EN
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
`endif
            end
            held_diff = diff;
            held_bor  = borrow_out;
            done_prev = 1'b1;
        end else begin
            chk("diff_hold", {24'd0, diff}, {24'd0, held_diff});
            chk("borrow_hold", {31'd0, borrow_out}, {31'd0, held_bor});
            done_prev = 1'b0;
        end
    end

    task automatic wait_done(output int t);
        int k;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        t = cyc_cnt;
    endtask

    // One operation with optional start pulse (a=FF,b=00) injected in RUN cycle inj.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input int inj);
        int cyc;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        sb.push_back('{diff: ed, bor: eb, ovf: eo});
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < 4 * W) begin
            @(negedge clk);
            cyc++;
            if (inj != 0 && cyc == inj) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'h00;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("latency", cyc, W);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_back_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t1;
        int t2;
        int t3;
        n_vec   = 0;
        n_err   = 0;
        cyc_cnt = 0;
        rst     = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
`endif
        #2 rst = 1'b0;

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);

        // Start during RUN is dropped: one result only, from the first operands.
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 3);
        repeat (12) @(negedge clk);
        chk("ignored_start_idle", {31'd0, busy}, 32'd0);
        chk("ignored_start_sb", sb.size(), 0);

        // Abort mid-RUN: outputs return to reset values, no done.
        @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_diff", {24'd0, diff}, 32'd0);
        chk("abort_borrow", {31'd0, borrow_out}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 0);

        // Start held high: accepts every W+2 cycles, operands swapped after each done.
        @(negedge clk);
        a     = 8'h37;
        b     = 8'h4C;
        start = 1'b1;
        sb.push_back('{diff: 8'hEB, bor: 1'b1, ovf: 1'b0});
        sb.push_back('{diff: 8'h64, bor: 1'b0, ovf: 1'b1});
        sb.push_back('{diff: 8'hFF, bor: 1'b1, ovf: 1'b1});
        wait_done(t1);
        a = 8'hC8;
        b = 8'h64;
        @(negedge clk);
        wait_done(t2);
        a = 8'h7F;
        b = 8'h80;
        @(negedge clk);
        wait_done(t3);
        start = 1'b0;
        chk("b2b_spacing_1", t2 - t1, W + 2);
        chk("b2b_spacing_2", t3 - t2, W + 2);
        repeat (14) @(negedge clk);
        chk("b2b_idle", {31'd0, busy}, 32'd0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
